// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: CPU, DMA and memory-side signals of the memory bus arbiter.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_ack;
    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_ack;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [1:0]        grant;
    logic              busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata, mem_rdata,
        output cpu_rdata, cpu_ack, dma_rdata, dma_ack,
        output mem_en, mem_we, mem_addr, mem_wdata, grant, busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata, mem_rdata,
        input  cpu_rdata, cpu_ack, dma_rdata, dma_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata, grant, busy
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin sharing of a single-port memory between CPU and DMA with wait states.
module mem_bus_arbiter #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input logic              clk,
    input logic              reset,
    mem_bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t            state, state_n;
    logic [3:0]        cnt, cnt_n;
    logic              last_dma, last_dma_n;
    logic              win_dma;
    logic              we_q, we_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [DATA_W-1:0] wdata_q, wdata_n;
    logic [1:0]        grant_q, grant_n;
    logic              mem_en_q, mem_en_n;
    logic              mem_we_q, mem_we_n;
    logic              busy_q, busy_n;
    logic              cpu_ack_q, cpu_ack_n;
    logic              dma_ack_q, dma_ack_n;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_n;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_n;

    // DMA wins when alone, or on a tie when the CPU was served last
    assign win_dma = bus.dma_req && (!bus.cpu_req || !last_dma);

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        last_dma_n  = last_dma;
        we_n        = we_q;
        addr_n      = addr_q;
        wdata_n     = wdata_q;
        grant_n     = grant_q;
        cpu_rdata_n = cpu_rdata_q;
        dma_rdata_n = dma_rdata_q;
        mem_en_n    = 1'b0;
        mem_we_n    = 1'b0;
        busy_n      = 1'b0;
        cpu_ack_n   = 1'b0;
        dma_ack_n   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cpu_req || bus.dma_req) begin
                    state_n    = ACCESS;
                    cnt_n      = 4'd0;
                    last_dma_n = win_dma;
                    grant_n    = win_dma ? 2'b10 : 2'b01;
                    we_n       = win_dma ? bus.dma_we : bus.cpu_we;
                    addr_n     = win_dma ? bus.dma_addr : bus.cpu_addr;
                    wdata_n    = win_dma ? bus.dma_wdata : bus.cpu_wdata;
                    mem_en_n   = 1'b1;
                    mem_we_n   = we_n;
                    busy_n     = 1'b1;
                end
            end
            ACCESS: begin
                busy_n = 1'b1;
                if (cnt == WS) begin
                    state_n     = DONE;
                    cpu_ack_n   = grant_q[0];
                    dma_ack_n   = grant_q[1];
                    cpu_rdata_n = (!we_q && grant_q[0]) ? bus.mem_rdata : cpu_rdata_q;
                    dma_rdata_n = (!we_q && grant_q[1]) ? bus.mem_rdata : dma_rdata_q;
                end else begin
                    cnt_n    = cnt + 4'd1;
                    mem_en_n = 1'b1;
                    mem_we_n = we_q;
                end
            end
            DONE: begin
                state_n = IDLE;
                grant_n = 2'b00;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            last_dma    <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            grant_q     <= 2'b00;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            last_dma    <= last_dma_n;
            we_q        <= we_n;
            addr_q      <= addr_n;
            wdata_q     <= wdata_n;
            grant_q     <= grant_n;
            mem_en_q    <= mem_en_n;
            mem_we_q    <= mem_we_n;
            busy_q      <= busy_n;
            cpu_ack_q   <= cpu_ack_n;
            dma_ack_q   <= dma_ack_n;
            cpu_rdata_q <= cpu_rdata_n;
            dma_rdata_q <= dma_rdata_n;
        end
    end

    // Latched address/data registers drive the memory directly, so they hold outside ACCESS
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.grant     = grant_q;
    assign bus.busy      = busy_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.dma_ack   = dma_ack_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dma_rdata = dma_rdata_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed bench for mem_bus_arbiter with one and zero wait states.
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_W(8), .DATA_W(8)) b1 ();
    mem_bus_arbiter_if #(.ADDR_W(8), .DATA_W(8)) b0 ();

    mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(1)) u1 (.clk(clk), .reset(reset), .bus(b1));
    mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(0)) u0 (.clk(clk), .reset(reset), .bus(b0));

    logic [7:0] mem [256];
    logic       ld = 1'b0;
    logic [7:0] ld_addr = 8'h00;
    logic [7:0] ld_data = 8'h00;

    always @(posedge clk)
        if (b1.mem_en && b1.mem_we) mem[b1.mem_addr] <= b1.mem_wdata;
        else if (ld) mem[ld_addr] <= ld_data;

    assign b1.mem_rdata = mem[b1.mem_addr];
    assign b0.mem_rdata = mem[b0.mem_addr];

    task tick;
        @(posedge clk);
        #1;
    endtask

    task poke(input logic [7:0] a, input logic [7:0] d);
        ld = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld = 1'b0;
    endtask

    task test_reset;
        reset = 1'b0;
        b1.cpu_req = 1'b1; b1.dma_req = 1'b1;
        tick(); tick();
        n_checks++; if (b1.grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant: got %b want 00", b1.grant); end
        n_checks++; if (b1.mem_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en: got %b want 0", b1.mem_en); end
        n_checks++; if (b1.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", b1.busy); end
        n_checks++; if ({b1.cpu_ack, b1.dma_ack, b1.mem_we} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes: got %b want 000", {b1.cpu_ack, b1.dma_ack, b1.mem_we}); end
        n_checks++; if ({b1.cpu_rdata, b1.dma_rdata, b1.mem_addr} !== 24'h0) begin n_fail++; $display("FAIL reset_data: got %h want 000000", {b1.cpu_rdata, b1.dma_rdata, b1.mem_addr}); end
        reset = 1'b1;
        tick();
        n_checks++; if (b1.grant !== 2'b01) begin n_fail++; $display("FAIL first_tie_grant: got %b want 01", b1.grant); end
        n_checks++; if ({b1.mem_en, b1.busy} !== 2'b11) begin n_fail++; $display("FAIL first_tie_en_busy: got %b want 11", {b1.mem_en, b1.busy}); end
        b1.cpu_req = 1'b0; b1.dma_req = 1'b0;
        tick(); tick(); tick();
    endtask

    task test_cpu_read;
        poke(8'h10, 8'h5A);
        b1.cpu_we = 1'b0; b1.cpu_addr = 8'h10; b1.cpu_req = 1'b1;
        tick();
        b1.cpu_req = 1'b0;
        n_checks++; if ({b1.mem_en, b1.mem_we, b1.mem_addr} !== {2'b10, 8'h10}) begin n_fail++; $display("FAIL rd_c1_mem: got en=%b we=%b addr=%h want en=1 we=0 addr=10", b1.mem_en, b1.mem_we, b1.mem_addr); end
        n_checks++; if ({b1.grant, b1.cpu_ack} !== 3'b010) begin n_fail++; $display("FAIL rd_c1_grant_ack: got %b want 010", {b1.grant, b1.cpu_ack}); end
        tick();
        n_checks++; if ({b1.mem_en, b1.cpu_ack} !== 2'b10) begin n_fail++; $display("FAIL rd_c2: got en/ack %b want 10", {b1.mem_en, b1.cpu_ack}); end
        tick();
        n_checks++; if ({b1.mem_en, b1.cpu_ack, b1.dma_ack} !== 3'b010) begin n_fail++; $display("FAIL rd_c3_strobes: got en/cack/dack %b want 010", {b1.mem_en, b1.cpu_ack, b1.dma_ack}); end
        n_checks++; if (b1.cpu_rdata !== 8'h5A) begin n_fail++; $display("FAIL rd_cpu_rdata: got %h want 5a", b1.cpu_rdata); end
        n_checks++; if (b1.dma_rdata !== 8'h00) begin n_fail++; $display("FAIL rd_dma_rdata: got %h want 00", b1.dma_rdata); end
        tick();
        n_checks++; if ({b1.cpu_ack, b1.busy, b1.grant} !== 4'b0000) begin n_fail++; $display("FAIL rd_c4_idle: got ack/busy/grant %b want 0000", {b1.cpu_ack, b1.busy, b1.grant}); end
    endtask

    task test_dma_write;
        b1.dma_we = 1'b1; b1.dma_addr = 8'h20; b1.dma_wdata = 8'h33; b1.dma_req = 1'b1;
        tick();
        b1.dma_req = 1'b0; b1.dma_wdata = 8'h00;
        n_checks++; if ({b1.mem_en, b1.mem_we, b1.grant} !== 4'b1110) begin n_fail++; $display("FAIL wr_c1: got en/we/grant %b want 1110", {b1.mem_en, b1.mem_we, b1.grant}); end
        tick();
        n_checks++; if ({b1.mem_we, b1.mem_wdata, b1.mem_addr} !== {1'b1, 8'h33, 8'h20}) begin n_fail++; $display("FAIL wr_c2: got we=%b wdata=%h addr=%h want 1 33 20", b1.mem_we, b1.mem_wdata, b1.mem_addr); end
        tick();
        n_checks++; if ({b1.dma_ack, b1.mem_we, b1.mem_en} !== 3'b100) begin n_fail++; $display("FAIL wr_c3: got ack/we/en %b want 100", {b1.dma_ack, b1.mem_we, b1.mem_en}); end
        n_checks++; if ({b1.dma_rdata, b1.cpu_rdata} !== 16'h005A) begin n_fail++; $display("FAIL wr_rdata_kept: got %h want 005a", {b1.dma_rdata, b1.cpu_rdata}); end
        tick();
        b1.dma_we = 1'b0;
        b1.cpu_addr = 8'h20; b1.cpu_req = 1'b1;
        tick();
        b1.cpu_req = 1'b0;
        tick(); tick();
        n_checks++; if ({b1.cpu_ack, b1.cpu_rdata} !== {1'b1, 8'h33}) begin n_fail++; $display("FAIL wr_readback: got ack=%b rdata=%h want 1 33", b1.cpu_ack, b1.cpu_rdata); end
        n_checks++; if (b1.dma_rdata !== 8'h00) begin n_fail++; $display("FAIL wr_dma_rdata: got %h want 00", b1.dma_rdata); end
        tick();
    endtask

    task test_round_robin;
        logic [1:0] e;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        b1.cpu_addr = 8'h01; b1.dma_addr = 8'h02;
        b1.cpu_req = 1'b1; b1.dma_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e = (i % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            n_checks++; if (b1.grant !== e) begin n_fail++; $display("FAIL rr_grant_%0d: got %b want %b", i, b1.grant, e); end
            b1.cpu_req = 1'b1; b1.dma_req = 1'b1;
            tick(); tick();
            n_checks++; if ({b1.cpu_ack, b1.dma_ack} !== {e[0], e[1]}) begin n_fail++; $display("FAIL rr_ack_%0d: got %b want %b", i, {b1.cpu_ack, b1.dma_ack}, {e[0], e[1]}); end
            if (e[0]) b1.cpu_req = 1'b0;
            else b1.dma_req = 1'b0;
            tick();
            n_checks++; if ({b1.grant, b1.cpu_ack, b1.dma_ack} !== 4'b0000) begin n_fail++; $display("FAIL rr_idle_%0d: got grant/acks %b want 0000", i, {b1.grant, b1.cpu_ack, b1.dma_ack}); end
        end
        b1.cpu_req = 1'b0; b1.dma_req = 1'b0;
    endtask

    task test_tie;
        b1.cpu_req = 1'b1; b1.dma_req = 1'b1;
        tick();
        n_checks++; if (b1.grant !== 2'b01) begin n_fail++; $display("FAIL tie_after_dma: got %b want 01", b1.grant); end
        b1.cpu_req = 1'b0;
        tick(); tick(); tick();
        tick();
        n_checks++; if (b1.grant !== 2'b10) begin n_fail++; $display("FAIL loser_served: got %b want 10", b1.grant); end
        b1.dma_req = 1'b0;
        tick(); tick(); tick();
        b1.dma_req = 1'b1;
        tick();
        n_checks++; if (b1.grant !== 2'b10) begin n_fail++; $display("FAIL dma_alone: got %b want 10", b1.grant); end
        b1.dma_req = 1'b0;
        tick(); tick(); tick();
        b1.cpu_req = 1'b1;
        tick();
        b1.cpu_req = 1'b0;
        tick(); tick(); tick();
        b1.cpu_req = 1'b1; b1.dma_req = 1'b1;
        tick();
        n_checks++; if (b1.grant !== 2'b10) begin n_fail++; $display("FAIL tie_after_cpu: got %b want 10", b1.grant); end
        b1.cpu_req = 1'b0; b1.dma_req = 1'b0;
        tick(); tick(); tick();
    endtask

    task test_latch_and_reset;
        poke(8'h44, 8'h99);
        b1.cpu_we = 1'b0; b1.cpu_addr = 8'h10; b1.cpu_req = 1'b1;
        tick();
        b1.cpu_req = 1'b0; b1.cpu_addr = 8'h44;
        n_checks++; if (b1.mem_addr !== 8'h10) begin n_fail++; $display("FAIL latch_c1_addr: got %h want 10", b1.mem_addr); end
        tick();
        n_checks++; if (b1.mem_addr !== 8'h10) begin n_fail++; $display("FAIL latch_c2_addr: got %h want 10", b1.mem_addr); end
        tick();
        n_checks++; if ({b1.cpu_ack, b1.cpu_rdata} !== {1'b1, 8'h5A}) begin n_fail++; $display("FAIL latch_rdata: got ack=%b rdata=%h want 1 5a", b1.cpu_ack, b1.cpu_rdata); end
        tick();
        b1.cpu_req = 1'b1;
        tick();
        reset = 1'b0; b1.cpu_req = 1'b0;
        tick();
        n_checks++; if ({b1.mem_en, b1.busy, b1.grant, b1.cpu_ack} !== 5'b00000) begin n_fail++; $display("FAIL midreset_outputs: got en/busy/grant/ack %b want 00000", {b1.mem_en, b1.busy, b1.grant, b1.cpu_ack}); end
        n_checks++; if (b1.cpu_rdata !== 8'h00) begin n_fail++; $display("FAIL midreset_rdata: got %h want 00", b1.cpu_rdata); end
        reset = 1'b1;
        tick();
        n_checks++; if ({b1.cpu_ack, b1.mem_en} !== 2'b00) begin n_fail++; $display("FAIL midreset_no_ack1: got ack/en %b want 00", {b1.cpu_ack, b1.mem_en}); end
        tick();
        n_checks++; if (b1.cpu_ack !== 1'b0) begin n_fail++; $display("FAIL midreset_no_ack2: got %b want 0", b1.cpu_ack); end
        b1.cpu_req = 1'b1;
        tick();
        b1.cpu_req = 1'b0;
        n_checks++; if ({b1.grant, b1.mem_addr} !== {2'b01, 8'h44}) begin n_fail++; $display("FAIL after_reset_grant: got grant=%b addr=%h want 01 44", b1.grant, b1.mem_addr); end
        tick(); tick();
        n_checks++; if ({b1.cpu_ack, b1.cpu_rdata} !== {1'b1, 8'h99}) begin n_fail++; $display("FAIL after_reset_read: got ack=%b rdata=%h want 1 99", b1.cpu_ack, b1.cpu_rdata); end
        tick();
    endtask

    task test_zero_wait;
        poke(8'h7F, 8'hC3);
        b0.dma_we = 1'b0; b0.dma_addr = 8'h7F; b0.dma_req = 1'b1;
        tick();
        b0.dma_req = 1'b0;
        n_checks++; if ({b0.mem_en, b0.mem_addr, b0.dma_ack} !== {1'b1, 8'h7F, 1'b0}) begin n_fail++; $display("FAIL zw_c1: got en=%b addr=%h ack=%b want 1 7f 0", b0.mem_en, b0.mem_addr, b0.dma_ack); end
        tick();
        n_checks++; if ({b0.dma_ack, b0.mem_en, b0.dma_rdata} !== {2'b10, 8'hC3}) begin n_fail++; $display("FAIL zw_c2: got ack=%b en=%b rdata=%h want 1 0 c3", b0.dma_ack, b0.mem_en, b0.dma_rdata); end
        tick();
        n_checks++; if ({b0.dma_ack, b0.busy, b0.grant} !== 4'b0000) begin n_fail++; $display("FAIL zw_c3: got ack/busy/grant %b want 0000", {b0.dma_ack, b0.busy, b0.grant}); end
    endtask

    initial begin
        b1.cpu_req = 1'b0; b1.cpu_we = 1'b0; b1.cpu_addr = 8'h00; b1.cpu_wdata = 8'h00;
        b1.dma_req = 1'b0; b1.dma_we = 1'b0; b1.dma_addr = 8'h00; b1.dma_wdata = 8'h00;
        b0.cpu_req = 1'b0; b0.cpu_we = 1'b0; b0.cpu_addr = 8'h00; b0.cpu_wdata = 8'h00;
        b0.dma_req = 1'b0; b0.dma_we = 1'b0; b0.dma_addr = 8'h00; b0.dma_wdata = 8'h00;
        test_reset();
        test_cpu_read();
        test_dma_write();
        test_round_robin();
        test_tie();
        test_latch_and_reset();
        test_zero_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
